// File: rtl/path_sprite_plotter_pkg.sv
// path_sprite_plotter_pkg
//   Shared definitions for the sprite plotting stages. It holds the FSM state
//   encodings, the default screen geometry and background colour, and a helper
//   that decides whether a pixel lies on the visible screen.
package path_sprite_plotter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ERASE = 2'd1;
    localparam state_t ST_DRAW  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BG_DEFAULT = 3'b000;

    // Scan coordinates cover sprite edges of 1..8 pixels.
    localparam int SCAN_W = 3;

    // The sums are one bit wider than the screen coordinates, so a sprite that
    // runs past the right or bottom edge is clipped rather than wrapped.
    function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy,
                                       input int xmax, input int ymax);
        return (sx < 9'(xmax)) && (sy < 8'(ymax));
    endfunction

endpackage

// File: rtl/path_sprite_plotter_scan.sv
// path_sprite_plotter_scan
//   SIZE x SIZE pixel scanner. It generates (px, py) with px changing fastest,
//   and it is reusable by other sprite stages.
// Ports
//   clk, resetn : clock, asynchronous active-low reset
//   start       : force the scan back to (0,0)
//   step        : advance one pixel; after the last pixel it wraps to (0,0)
//   px, py      : current pixel offset inside the sprite
//   last        : the current offset is the final pixel (SIZE-1, SIZE-1)
module path_sprite_plotter_scan
    import path_sprite_plotter_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              step,
    output logic [SCAN_W-1:0] px,
    output logic [SCAN_W-1:0] py,
    output logic              last
);

    localparam logic [SCAN_W-1:0] LAST_IDX = SCAN_W'(SIZE - 1);

    // The wrap after the final pixel lets one phase of the scan start the next
    // without an explicit restart.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            px <= '0;
            py <= '0;
        end else if (start) begin
            px <= '0;
            py <= '0;
        end else if (step) begin
            if (px == LAST_IDX) begin
                px <= '0;
                if (py == LAST_IDX) begin
                    py <= '0;
                end else begin
                    py <= py + 1'b1;
                end
            end else begin
                px <= px + 1'b1;
            end
        end
    end

    assign last = (px == LAST_IDX) && (py == LAST_IDX);

endmodule

// File: rtl/path_sprite_plotter.sv
// path_sprite_plotter
//   Accepts one path point per handshake and paints a SIZE x SIZE sprite at it.
//   It first erases the sprite at the previously accepted point with BG_COLOR.
//   Pixels go to the VGA adapter write port at one per clock.
// Ports
//   clk, resetn                : clock, asynchronous active-low reset
//   in_valid/in_ready          : point handshake (ready only while idle)
//   in_x, in_y, in_color       : top-left corner and colour of the sprite
//   clear                      : forget the previous point (no erase next time)
//   vga_x, vga_y, vga_colour   : registered pixel to the adapter
//   plot                       : adapter write enable (on-screen pixels only)
//   busy                       : erasing, drawing or finishing a point
module path_sprite_plotter
    import path_sprite_plotter_pkg::*;
#(
    parameter int         SIZE     = 4,
    parameter logic [2:0] BG_COLOR = BG_DEFAULT,
    parameter int         X_MAX    = SCREEN_W,
    parameter int         Y_MAX    = SCREEN_H
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_color,
    input  logic       clear,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy
);

    state_t            state;
    logic [7:0]        new_x;
    logic [6:0]        new_y;
    logic [2:0]        new_col;
    logic [7:0]        old_x;
    logic [6:0]        old_y;
    logic              has_old;
    logic              clear_pend;

    logic              scanning;
    logic [SCAN_W-1:0] px;
    logic [SCAN_W-1:0] py;
    logic              scan_last;

    logic [7:0]        base_x;
    logic [6:0]        base_y;
    logic [2:0]        colour_sel;
    logic [8:0]        sx;
    logic [7:0]        sy;

    assign scanning = (state == ST_ERASE) || (state == ST_DRAW);
    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;

    // The scanner sits at (0,0) while idle, so an accepted point always starts
    // from the sprite's top-left pixel.
    path_sprite_plotter_scan #(
        .SIZE (SIZE)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .start  (in_ready),
        .step   (scanning),
        .px     (px),
        .py     (py),
        .last   (scan_last)
    );

    // Erase paints the old sprite with the background colour. Draw paints the
    // new one.
    always_comb begin
        base_x     = new_x;
        base_y     = new_y;
        colour_sel = new_col;
        if (state == ST_ERASE) begin
            base_x     = old_x;
            base_y     = old_y;
            colour_sel = BG_COLOR;
        end
        sx = {1'b0, base_x} + {6'b0, px};
        sy = {1'b0, base_y} + {5'b0, py};
    end

    // Sequencing and bookkeeping. A clear seen mid-sprite is held in clear_pend
    // until DONE decides whether the new point must be erased next time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            new_x      <= '0;
            new_y      <= '0;
            new_col    <= '0;
            old_x      <= '0;
            old_y      <= '0;
            has_old    <= 1'b0;
            clear_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        new_x   <= in_x;
                        new_y   <= in_y;
                        new_col <= in_color;
                        state   <= (has_old && !clear) ? ST_ERASE : ST_DRAW;
                    end else if (clear) begin
                        has_old <= 1'b0;
                    end
                end
                ST_ERASE: begin
                    if (clear) begin
                        clear_pend <= 1'b1;
                    end
                    if (scan_last) begin
                        state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (clear) begin
                        clear_pend <= 1'b1;
                    end
                    if (scan_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    old_x      <= new_x;
                    old_y      <= new_y;
                    has_old    <= ~(clear_pend | clear);
                    clear_pend <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The pixel for the current scan position is registered, so the adapter sees
    // it one cycle later. A clipped pixel still updates the coordinates and only
    // suppresses plot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
        end else if (scanning) begin
            vga_x      <= sx[7:0];
            vga_y      <= sy[6:0];
            vga_colour <= colour_sel;
            plot       <= on_screen(sx, sy, X_MAX, Y_MAX);
        end else begin
            plot       <= 1'b0;
        end
    end

endmodule
